// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int width = 32
) ();
  logic             imem_req;
  logic [width-1:0] imem_addr;
  logic             imem_ack;
  logic [width-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches one instruction per
// request/ack handshake, presents it for exactly one EXEC cycle, and
// provides run/step control, a sticky fetch timeout and a retire counter.
module fetch_sequencer #(
  parameter int               width        = 32,
  parameter logic [width-1:0] RESET_VECTOR = '0,
  parameter int               TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  fetch_sequencer_if.master imem,
  input  logic              Jump,
  input  logic              PCSrc,
  input  logic [width-1:0]  PCBranch,
  output logic [width-1:0]  PC,
  output logic [width-1:0]  PCPlus4,
  output logic [width-1:0]  Instr,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic [31:0]       retire_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

  localparam int cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [cnt_w-1:0] last_wait = cnt_w'(TIMEOUT - 1);

  state_t           state, state_next;
  logic             single;
  logic [cnt_w-1:0] tmo_cnt;
  logic [width-1:0] pc_next;
  logic [width-1:0] jump_target;

  // Outputs come from registered state only, so no input reaches them
  // combinationally.
  assign PCPlus4        = PC + width'(4);
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = PC;
  assign instr_valid    = (state == EXEC);
  assign fetch_err      = (state == ERR);

  assign jump_target = {PCPlus4[width-1:28], Instr[25:0], 2'b00};

  // Next-PC selection: jump beats branch beats sequential.
  always_comb begin
    pc_next = PCPlus4;
    if (Jump)       pc_next = jump_target;
    else if (PCSrc) pc_next = PCBranch;
  end

  // Next-state logic for the IDLE/FETCH/EXEC/ERR controller.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  if (run || step) state_next = FETCH;
      FETCH: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (imem.imem_ack)           state_next = EXEC;
        else if (tmo_cnt == last_wait) state_next = ERR;
      end
      EXEC:  state_next = (run && !single) ? FETCH : IDLE;
      ERR:   state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the PC, instruction latch, timeout and retire counters.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state      <= IDLE;
      PC         <= RESET_VECTOR;
      Instr      <= '0;
      retire_cnt <= '0;
      single     <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          // run has priority; a step alone marks this as a one-shot fetch.
          if (!run && step) single <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            Instr   <= imem.imem_rdata;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        EXEC: begin
          PC         <= pc_next;
          retire_cnt <= retire_cnt + 32'd1;
          single     <= 1'b0;
        end
        ERR: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a table of fetch/next-PC vectors
// under continuous run, then hand-written step, run-drop, timeout and
// reset sequences. A scoreboard pairs each acked fetch with its EXEC pulse.
module tb_fetch_sequencer;

  localparam int W   = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          Jump = 1'b0;
  logic          PCSrc = 1'b0;
  logic [W-1:0]  PCBranch = '0;
  logic [W-1:0]  PC, PCPlus4, Instr;
  logic          instr_valid, fetch_err;
  logic [31:0]   retire_cnt;

  fetch_sequencer_if #(.width(W)) bus ();

  fetch_sequencer #(.width(W), .RESET_VECTOR('0), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .imem        (bus),
    .Jump        (Jump),
    .PCSrc       (PCSrc),
    .PCBranch    (PCBranch),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_valid = 0;
  logic [31:0] exp_retire = '0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [31:0] addr;
    int          waits;
    logic [31:0] instr;
    logic        j;
    logic        b;
    logic [31:0] tgt;
    logic [31:0] next;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every EXEC pulse must match the oldest acked fetch.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid: got instr_valid with PC %h, expected none", PC);
      end else begin
        mon_e = sb.pop_front();
        check("sb_instr", Instr, mon_e.instr);
        check("sb_pc", PC, mon_e.addr);
      end
    end
  end

  // Serve one fetch: wait for the request, hold ack off for 'waits' cycles,
  // ack, then drive the control inputs during the EXEC cycle.
  task automatic fetch_one(input logic [31:0] exp_addr, input int waits,
                           input logic [31:0] rdata, input logic j, input logic b,
                           input logic [31:0] tgt, input logic run_after,
                           input logic gap_chk);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'b0, bus.imem_req}, 32'd1);
    check("fetch_addr", bus.imem_addr, exp_addr);
    run = run_after;
    for (int i = 0; i < waits; i++) begin
      step = 1'b1;
      @(negedge clk);
      check("req_hold", {31'b0, bus.imem_req}, 32'd1);
      check("addr_hold", bus.imem_addr, exp_addr);
    end
    step = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    sb.push_back('{exp_addr, rdata});
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    if (gap_chk) check("valid_gap", 32'(cyc - last_valid), 32'(waits + 2));
    last_valid = cyc;
    Jump = j;
    PCSrc = b;
    PCBranch = tgt;
    exp_retire++;
    @(negedge clk);
    Jump = 1'b0;
    PCSrc = 1'b0;
    PCBranch = '0;
    check("valid_pulse", {31'b0, instr_valid}, 32'd0);
    check("retire_cnt", retire_cnt, exp_retire);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         32'h0000_0004};
    vecs[1] = '{32'h0000_0004, 0, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         32'h0000_0008};
    vecs[2] = '{32'h0000_0008, 0, 32'h3333_3333, 1'b0, 1'b0, 32'h0,         32'h0000_000C};
    vecs[3] = '{32'h0000_000C, 0, 32'h4444_4444, 1'b0, 1'b1, 32'h0040_0010, 32'h0040_0010};
    vecs[4] = '{32'h0040_0010, 0, 32'h0800_0100, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0400};
    vecs[5] = '{32'h0000_0400, 2, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0080};
    vecs[6] = '{32'h0000_0080, 1, 32'h6666_6666, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[7] = '{32'hFFFF_FFFC, 0, 32'h7777_7777, 1'b0, 1'b0, 32'h0,         32'h0000_0000};
    vecs[8] = '{32'h0000_0000, 3, 32'h0BFF_FFFF, 1'b1, 1'b0, 32'h0,         32'h0FFF_FFFC};
    vecs[9] = '{32'h0FFF_FFFC, 0, 32'h9999_9999, 1'b0, 1'b0, 32'h0,         32'h1000_0000};

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", PC, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    check("rst_instr", Instr, 32'h0);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);

    // Continuous run through the vector table; the last one drops run.
    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch_one(vecs[i].addr, vecs[i].waits, vecs[i].instr, vecs[i].j, vecs[i].b,
                vecs[i].tgt, (i == 9) ? 1'b0 : 1'b1, (i > 0) ? 1'b1 : 1'b0);
      check("next_pc", PC, vecs[i].next);
    end
    check("run_end_idle", {31'b0, bus.imem_req}, 32'd0);

    // Single step with a taken branch: one instruction, then IDLE at 0x80.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_req_latency", {31'b0, bus.imem_req}, 32'd1);
    fetch_one(32'h1000_0000, 0, 32'hAAAA_AAAA, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    check("step_pc", PC, 32'h0000_0080);
    for (int i = 0; i < 3; i++) begin
      check("step_idle_req", {31'b0, bus.imem_req}, 32'd0);
      @(negedge clk);
    end

    // run dropped in the first FETCH cycle of a 3-wait fetch; step pulses ignored.
    run = 1'b1;
    fetch_one(32'h0000_0080, 3, 32'hBBBB_BBBB, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("drop_pc", PC, 32'h0000_0084);
    for (int i = 0; i < 3; i++) begin
      check("drop_idle_req", {31'b0, bus.imem_req}, 32'd0);
      @(negedge clk);
    end

    // Timeout: no ack for TMO FETCH cycles.
    run = 1'b1;
    begin
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < TMO; k++) begin
      check("tmo_req", {31'b0, bus.imem_req}, 32'd1);
      check("tmo_err_low", {31'b0, fetch_err}, 32'd0);
      @(negedge clk);
    end
    check("tmo_err", {31'b0, fetch_err}, 32'd1);
    check("tmo_req_low", {31'b0, bus.imem_req}, 32'd0);
    check("tmo_pc", PC, 32'h0000_0084);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hCCCC_CCCC;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("err_sticky", {31'b0, fetch_err}, 32'd1);
    check("err_no_valid", {31'b0, instr_valid}, 32'd0);
    check("err_pc", PC, 32'h0000_0084);
    check("err_instr", Instr, 32'hBBBB_BBBB);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_retire = '0;
    check("err_rst_pc", PC, 32'h0);
    check("err_rst_err", {31'b0, fetch_err}, 32'd0);
    check("err_rst_retire", retire_cnt, 32'd0);
    check("err_rst_instr", Instr, 32'h0);

    // Ack in the last allowed FETCH cycle wins over the timeout.
    run = 1'b1;
    fetch_one(32'h0000_0000, TMO - 1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("late_ack_err", {31'b0, fetch_err}, 32'd0);
    check("late_ack_pc", PC, 32'h0000_0004);
    check("late_ack_idle", {31'b0, bus.imem_req}, 32'd0);

    // Reset in the middle of a fetch.
    run = 1'b1;
    begin
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_req", {31'b0, bus.imem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    exp_retire = '0;
    @(negedge clk);
    check("mid_rst_idle", {31'b0, bus.imem_req}, 32'd0);
    check("mid_rst_pc", PC, 32'h0);
    check("mid_rst_retire", retire_cnt, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the program counter against an instruction memory with a request/acknowledge handshake. It owns the PC register and next-PC selection (sequential, branch, jump) and presents each fetched instruction to the decode/execute datapath for exactly one cycle. It also provides run/halt/single-step control, a fetch timeout error, and a retired-instruction counter. It sits between the instruction memory and the control/ALU datapath, and lets the core run against multi-cycle memories.

## Interface
Parameters:
- width, 32: PC/instruction/data width; jump-target math assumes 32.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- TIMEOUT, 16: max FETCH cycles without `imem_ack` before error; minimum 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = fetch continuously.
- step  in  1  pulse; fetch and execute one instruction, sampled only in IDLE.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  width  fetch address (= PC), stable while `imem_req`=1.
- imem_ack  in  1  one-cycle acknowledge; `imem_rdata` valid same cycle.
- imem_rdata  in  width  instruction word.
- Jump  in  1  from control; valid while `instr_valid`=1.
- PCSrc  in  1  branch taken; valid while `instr_valid`=1.
- PCBranch  in  width  branch target; valid while `instr_valid`=1.
- PC  out  width  current PC register.
- PCPlus4  out  width  PC + 4, modulo 2^width.
- Instr  out  width  latched instruction.
- instr_valid  out  1  one-cycle pulse; datapath commits state this cycle.
- fetch_err  out  1  sticky timeout flag.
- retire_cnt  out  32  instructions executed, wraps at 2^32.

## Operation
- States: IDLE, FETCH, EXEC, ERR.
- IDLE: `imem_req`=0. If `run`=1, go to FETCH. Else if `step`=1, go to FETCH with the internal `single` flag set. `run` takes priority over `step`. `imem_ack` is ignored in this state.
- FETCH: `imem_req`=1, `imem_addr`=PC, and the timeout counter increments.
  - On `imem_ack`: latch `imem_rdata` into `Instr`, clear the counter, go to EXEC.
  - If the counter reaches TIMEOUT with no ack: go to ERR.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- EXEC: `instr_valid`=1. At the clock edge, PC is loaded with the next PC, with this priority:
  - `Jump`=1: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - else `PCSrc`=1: PCBranch.
  - else: PCPlus4.
  - `Jump` takes priority over `PCSrc` when both are set.
  - `retire_cnt` increments.
  - Next state is FETCH if `run`=1 and `single`=0; otherwise IDLE, and `single` clears.
- ERR: `imem_req`=0, `instr_valid`=0, `fetch_err`=1, PC frozen. Only `rst` leaves this state.
- `run` deasserted during FETCH does not abort the fetch; the instruction completes through EXEC, then the block goes to IDLE.
- PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. PCBranch is loaded unmodified; no alignment check.

## Timing
- Reset (synchronous, `rst`=1 at an edge) forces: state=IDLE, PC=RESET_VECTOR, Instr=0, imem_req=0, instr_valid=0, fetch_err=0, retire_cnt=0, single=0, timeout counter=0. This takes effect from any state, including mid-FETCH; `imem_req` is low the cycle after the edge.
- `imem_addr`, `PCPlus4` and `imem_req` are derived from registered state only, with no combinational input-to-output path. `imem_ack` may arrive in the first FETCH cycle.
- Minimum throughput is 2 cycles per instruction (FETCH, EXEC). Each extra memory wait cycle adds 1.
- IDLE to first `imem_req` takes 1 cycle after `run` or `step` is sampled.
- The updated PC is visible the cycle after EXEC, coinciding with the next FETCH.
- ERR is entered at the edge of the TIMEOUT-th FETCH cycle without ack. `fetch_err` is high from the next cycle.

## Test plan
- Reset then `run`=1 with a zero-wait memory: `imem_addr` sequence 0, 4, 8, 12. `instr_valid` pulses every 2nd cycle. `retire_cnt`=4 after 8 cycles.
- Jump at PC=0x0040_0010 with Instr[25:0]=0x0000100: next `imem_addr`=0x0000_0400. Set `Jump`=`PCSrc`=1 with PCBranch=0x200: the jump target is taken.
- Branch: `PCSrc`=1, PCBranch=0x0000_0080 → next fetch at 0x80. With `run`=0, one `step` pulse → exactly one `instr_valid`, then back to IDLE, PC=0x80.
- 3-wait-state memory, `run` dropped during FETCH → `imem_addr` stable for 4 cycles, one `instr_valid`, then IDLE. `step` pulses during FETCH are ignored.
- No ack for TIMEOUT=16 cycles → `fetch_err`=1, `imem_req`=0, PC unchanged. Later acks are ignored. `rst` clears everything, PC=RESET_VECTOR. Ack on cycle 16 → normal EXEC, no error.
- PC=0xFFFF_FFFC, no branch → next `imem_addr`=0. Assert `rst` in the middle of FETCH → `imem_req`=0 next cycle, state IDLE.
